// File: rtl/prm_sequencer_pkg.sv
// Shared definitions for prm_sequencer: router select codes, opcodes and FSM state encodings.
package prm_sequencer_pkg;

  typedef enum logic [1:0] {
    PRM_NONE    = 2'd0,
    PRM_ADR     = 2'd1,
    PRM_JMP     = 2'd2,
    PRM_ADD_SUB = 2'd3
  } prm_sel_e;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_STA = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JZ  = 4'd6;
  localparam logic [3:0] OP_HLT = 4'd15;

  // S_STEP is only reachable in the single-step build: it parks the FSM until a step edge.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5,
    S_STEP   = 3'd6
  } state_e;

  function automatic prm_sel_e op_to_sel(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: return PRM_ADR;
      OP_ADD, OP_SUB: return PRM_ADD_SUB;
      OP_JMP, OP_JZ:  return PRM_JMP;
      default:        return PRM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/prm_sequencer_if.sv
// Sequencer-side bus: instruction fetch, parameter-router drive, ALU/accumulator strobes and data-memory handshake.
interface prm_sequencer_if #(parameter int PC_W = 4);
  logic [PC_W-1:0] pc;
  logic            imem_rd;
  logic [7:0]      instr;
  logic [1:0]      prm_select;
  logic [3:0]      prm_param;
  logic            acc_we;
  logic            alu_en;
  logic            alu_sub;
  logic            zero_flag;
  logic            mem_req;
  logic            mem_we;
  logic            mem_ack;
  logic            jmp_load;

  modport master (
    output pc, imem_rd, prm_select, prm_param, acc_we, alu_en, alu_sub,
           mem_req, mem_we, jmp_load,
    input  instr, zero_flag, mem_ack
  );

  modport slave (
    input  pc, imem_rd, prm_select, prm_param, acc_we, alu_en, alu_sub,
           mem_req, mem_we, jmp_load,
    output instr, zero_flag, mem_ack
  );
endinterface

// File: rtl/prm_seq_timeout.sv
// Data-memory ack watchdog: counts un-acked wait cycles and flags expiry on the ACK_TO-th one.
module prm_seq_timeout #(
  parameter int ACK_TO = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)     cnt_d = '0;
    else if (tick) cnt_d = cnt_q + 8'd1;
  end

  // Expiry is the cycle on which the count would reach ACK_TO; an ack that same cycle raises clear and wins.
  assign expire = tick && !clear && (cnt_q == 8'(ACK_TO - 1));

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/prm_sequencer.sv
// Fetch/decode/execute controller driving the parameter router, ALU, data memory and PC.
// Optional single-step fetch gating is enabled with `define PRM_SEQ_SINGLE_STEP_EN.
module prm_sequencer
  import prm_sequencer_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int ACK_TO = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
`ifdef PRM_SEQ_SINGLE_STEP_EN
  input  logic step,
`endif
  prm_sequencer_if.master bus,
  output logic busy,
  output logic halted,
  output logic err
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            err_q, err_d;
  logic            by_to_q, by_to_d;
  logic            start_q;
  logic            start_rise;
  logic            in_mem;
  logic            ack_expire;
  logic [3:0]      op, prm;
  logic [PC_W-1:0] pc_inc, jmp_tgt;
  prm_sel_e        exec_sel;

  assign op         = ir_q[7:4];
  assign prm        = ir_q[3:0];
  assign pc_inc     = pc_q + PC_W'(1);
  assign jmp_tgt    = PC_W'(prm);
  assign exec_sel   = op_to_sel(op);
  assign in_mem     = (state_q == S_MEM);
  assign start_rise = start && !start_q;

`ifdef PRM_SEQ_SINGLE_STEP_EN
  localparam state_e FETCH_ENTRY = S_STEP;
  logic step_q;
  logic step_rise;
  assign step_rise = step && !step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
`else
  localparam state_e FETCH_ENTRY = S_FETCH;
`endif

  prm_seq_timeout #(.ACK_TO(ACK_TO)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_mem || bus.mem_ack),
    .tick   (in_mem),
    .expire (ack_expire)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;
    by_to_d = by_to_q;
    case (state_q)
      S_IDLE:   if (start) state_d = FETCH_ENTRY;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = bus.instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = FETCH_ENTRY;
        pc_d    = pc_inc;
        case (op)
          OP_LDA, OP_STA: begin
            state_d = S_MEM;
            pc_d    = pc_q;
          end
          OP_HLT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
            by_to_d = 1'b0;
          end
          OP_JMP: pc_d = jmp_tgt;
          OP_JZ:  if (bus.zero_flag) pc_d = jmp_tgt;
          default: ;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          pc_d    = pc_inc;
          state_d = FETCH_ENTRY;
        end else if (ack_expire) begin
          err_d   = 1'b1;
          by_to_d = 1'b1;
          state_d = S_HALT;
        end
      end
      // A timeout halt resumes past the failed access; an HLT halt refetches the same slot.
      S_HALT: begin
        if (start_rise) begin
          state_d = FETCH_ENTRY;
          err_d   = 1'b0;
          if (by_to_q) pc_d = pc_inc;
        end
      end
`ifdef PRM_SEQ_SINGLE_STEP_EN
      S_STEP:  if (step_rise) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
      by_to_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      by_to_q <= by_to_d;
      start_q <= start;
    end
  end

  // Outputs decode from the state flop, so an async reset clears them at once;
  // only jmp_load (zero_flag) and the load acc_we (mem_ack) look at same-cycle inputs.
  always_comb begin
    bus.imem_rd    = 1'b0;
    bus.prm_select = PRM_NONE;
    bus.prm_param  = 4'd0;
    bus.acc_we     = 1'b0;
    bus.alu_en     = 1'b0;
    bus.alu_sub    = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.jmp_load   = 1'b0;
    case (state_q)
      S_FETCH: bus.imem_rd = 1'b1;
      S_EXEC: begin
        bus.prm_select = exec_sel;
        if (exec_sel != PRM_NONE) bus.prm_param = prm;
        bus.alu_en   = (op == OP_ADD) || (op == OP_SUB);
        bus.acc_we   = (op == OP_ADD) || (op == OP_SUB);
        bus.alu_sub  = (op == OP_SUB);
        bus.jmp_load = (op == OP_JMP) || ((op == OP_JZ) && bus.zero_flag);
      end
      S_MEM: begin
        bus.mem_req    = 1'b1;
        bus.mem_we     = (op == OP_STA);
        bus.prm_select = PRM_ADR;
        bus.prm_param  = prm;
        bus.acc_we     = bus.mem_ack && (op == OP_LDA);
      end
      default: ;
    endcase
  end

  assign bus.pc = pc_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);
  assign err    = err_q;

endmodule

// File: tb/tb_prm_sequencer.sv
// Self-checking bench for prm_sequencer (free-running fetch build): directed program plus
// randomized instruction stream compared cycle by cycle against an instruction-level model.
module tb_prm_sequencer;

  localparam int PC_W   = 4;
  localparam int ACK_TO = 8;

  typedef struct packed {
    logic       imem_rd;
    logic [1:0] sel;
    logic [3:0] param;
    logic       acc_we;
    logic       alu_en;
    logic       alu_sub;
    logic       mem_req;
    logic       mem_we;
    logic       jmp_load;
    logic       busy;
    logic       halted;
    logic       err;
    logic [3:0] pc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, halted, err;
  logic [7:0] imem [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the architecturally visible state.
  logic [3:0] m_pc;
  bit         m_err, m_to, m_halted;

  prm_sequencer_if #(.PC_W(PC_W)) bus ();

  prm_sequencer #(.PC_W(PC_W), .ACK_TO(ACK_TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .halted (halted),
    .err    (err)
  );

  always #5 clk = ~clk;

  assign bus.instr = imem[bus.pc];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t s;
    s.imem_rd  = bus.imem_rd;
    s.sel      = bus.prm_select;
    s.param    = bus.prm_param;
    s.acc_we   = bus.acc_we;
    s.alu_en   = bus.alu_en;
    s.alu_sub  = bus.alu_sub;
    s.mem_req  = bus.mem_req;
    s.mem_we   = bus.mem_we;
    s.jmp_load = bus.jmp_load;
    s.busy     = busy;
    s.halted   = halted;
    s.err      = err;
    s.pc       = bus.pc;
    return s;
  endfunction

  function automatic obs_t busy_vec();
    obs_t e;
    e      = '0;
    e.busy = 1'b1;
    e.pc   = m_pc;
    return e;
  endfunction

  function automatic obs_t halt_vec();
    obs_t e;
    e        = '0;
    e.halted = 1'b1;
    e.err    = m_err;
    e.pc     = m_pc;
    return e;
  endfunction

  // Runs one instruction starting from the cycle before its fetch. waits = un-acked
  // memory cycles before the ack (>= ACK_TO means the ack never comes); z = zero_flag.
  task automatic run_instr(input int waits, input bit z);
    logic [7:0] ins;
    logic [3:0] op, p;
    obs_t       e;
    bit         acked;
    ins   = imem[m_pc];
    op    = ins[7:4];
    p     = ins[3:0];
    acked = 1'b0;

    @(negedge clk);
    bus.mem_ack = 1'($urandom); start = 1'($urandom); bus.zero_flag = z;
    #1;
    e = busy_vec(); e.imem_rd = 1'b1;
    check("fetch", 32'(sample()), 32'(e));

    @(negedge clk);
    bus.mem_ack = 1'($urandom); start = 1'($urandom);
    #1;
    e = busy_vec();
    check("decode", 32'(sample()), 32'(e));

    @(negedge clk);
    bus.mem_ack = 1'($urandom); start = 1'b1;
    #1;
    e = busy_vec();
    if (op == 4'd1 || op == 4'd2)      e.sel = 2'd1;
    else if (op == 4'd3 || op == 4'd4) e.sel = 2'd3;
    else if (op == 4'd5 || op == 4'd6) e.sel = 2'd2;
    if (e.sel != 2'd0) e.param = p;
    e.alu_en   = (op == 4'd3 || op == 4'd4);
    e.acc_we   = (op == 4'd3 || op == 4'd4);
    e.alu_sub  = (op == 4'd4);
    e.jmp_load = (op == 4'd5) || (op == 4'd6 && z);
    check("exec", 32'(sample()), 32'(e));

    if (op == 4'd1 || op == 4'd2) begin
      for (int c = 1; c <= ACK_TO; c++) begin
        @(negedge clk);
        bus.mem_ack = (c > waits);
        #1;
        e = busy_vec();
        e.mem_req = 1'b1;
        e.mem_we  = (op == 4'd2);
        e.sel     = 2'd1;
        e.param   = p;
        e.acc_we  = (c > waits) && (op == 4'd1);
        check("mem", 32'(sample()), 32'(e));
        if (c > waits) begin
          acked = 1'b1;
          break;
        end
      end
      if (acked) m_pc = m_pc + 4'd1;
      else begin
        m_err = 1'b1; m_to = 1'b1; m_halted = 1'b1;
      end
    end else if (op == 4'd15) begin
      m_halted = 1'b1; m_to = 1'b0;
    end else if (op == 4'd5 || (op == 4'd6 && z)) begin
      m_pc = p;
    end else begin
      m_pc = m_pc + 4'd1;
    end

    if (m_halted) begin
      @(negedge clk);
      bus.mem_ack = 1'($urandom);
      #1;
      check("halt_entry", 32'(sample()), 32'(halt_vec()));
    end
  endtask

  // Drops start for a cycle, then raises it; the rising edge releases the halt.
  task automatic resume();
    @(negedge clk);
    start = 1'b0; bus.mem_ack = 1'($urandom);
    #1;
    check("halt_hold", 32'(sample()), 32'(halt_vec()));
    @(negedge clk);
    start = 1'b1; bus.mem_ack = 1'($urandom);
    #1;
    check("halt_edge", 32'(sample()), 32'(halt_vec()));
    if (m_to) m_pc = m_pc + 4'd1;
    m_err = 1'b0; m_to = 1'b0; m_halted = 1'b0;
  endtask

  obs_t zero_obs;

  initial begin
    zero_obs = '0;
    rst_n = 1'b0; start = 1'b0;
    bus.mem_ack = 1'b0; bus.zero_flag = 1'b0;
    m_pc = '0; m_err = 1'b0; m_to = 1'b0; m_halted = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    imem[0] = 8'h35; imem[1] = 8'h42; imem[2] = 8'hF0;

    #3;
    check("reset", 32'(sample()), 32'(zero_obs));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_hold", 32'(sample()), 32'(zero_obs));
    start = 1'b1;

    // ADD 5, SUB 2, HLT
    run_instr(0, 1'b0);
    run_instr(0, 1'b0);
    run_instr(0, 1'b0);
    check("hlt_pc", 32'(bus.pc), 32'd2);

    // LDA 7 acked after two waits, JZ taken, JMP back, JZ not taken
    imem[2] = 8'h17; imem[3] = 8'h6A; imem[10] = 8'h53;
    resume();
    run_instr(2, 1'b0);
    run_instr(0, 1'b1);
    run_instr(0, 1'b0);
    run_instr(0, 1'b0);
    check("jz_fallthrough_pc", 32'(m_pc), 32'd4);

    // STA with no ack -> timeout halt, then resume past it
    imem[4] = 8'h25;
    run_instr(100, 1'b0);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_mem_req", 32'(bus.mem_req), 32'd0);
    resume();

    // JMP 15 then NOP at pc=15 wraps to 0
    imem[5] = 8'h5F; imem[15] = 8'h00;
    run_instr(0, 1'b0);
    run_instr(0, 1'b0);

    // Ack on the timeout cycle succeeds; one cycle later it is a timeout
    imem[0] = 8'h1C; imem[1] = 8'h2D;
    run_instr(ACK_TO - 1, 1'b0);
    run_instr(ACK_TO, 1'b0);
    resume();

    for (int i = 0; i < 16; i++) imem[i] = 8'($urandom);
    for (int n = 0; n < 300; n++) begin
      if (m_halted) begin
        if (!m_to) imem[m_pc] = {4'($urandom_range(0, 14)), 4'($urandom)};
        resume();
      end
      run_instr(int'($urandom_range(0, ACK_TO + 1)), 1'($urandom));
    end

    // Reset in the middle of a memory wait
    if (m_halted) resume();
    imem[m_pc] = 8'h29;
    bus.zero_flag = 1'b0; bus.mem_ack = 1'b0; start = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("mem_req_pre_rst", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem", 32'(sample()), 32'(zero_obs));
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
